// File: rtl/tone_sequencer_if.sv
// Control-side bundle for tone_sequencer: note table writes, playback control
// and the generator-facing outputs.
interface tone_sequencer_if #(
  parameter int unsigned AW    = 4,
  parameter int unsigned HP_W  = 20,
  parameter int unsigned DUR_W = 16
);
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [HP_W+DUR_W-1:0]   wr_data;
  logic                    start;
  logic                    stop;
  logic                    loop;
  logic [AW:0]             num_notes;
  logic                    busy;
  logic                    done;
  logic [AW-1:0]           note_idx;
  logic                    tone_en;
  logic [HP_W-1:0]         half_period;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop, num_notes,
    input  busy, done, note_idx, tone_en, half_period
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop, num_notes,
    output busy, done, note_idx, tone_en, half_period
  );
endinterface

// File: rtl/tone_sequencer.sv
// Plays a sequence of notes from an internal table by driving the half-period
// and enable of a square-wave generator, with an optional silent gap per note.
module tone_sequencer #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned HP_W     = 20,
  parameter int unsigned DUR_W    = 16,
  parameter int unsigned GAP_MS   = 10
) (
  input  logic              clk,
  input  logic              rst,
  tone_sequencer_if.slave   bus
);

  localparam int unsigned MS_COUNT = CLK_FREQ / 1000;
  localparam int unsigned PW       = (MS_COUNT > 1) ? $clog2(MS_COUNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  logic [HP_W+DUR_W-1:0] r_mem [DEPTH];

  state_t            r_state, w_state;
  logic [AW-1:0]     r_idx, w_idx;
  logic [AW:0]       r_num, w_num;
  logic              r_loop, w_loop;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_tone, w_tone;
  logic [HP_W-1:0]   r_hp, w_hp;
  logic [PW-1:0]     r_presc, w_presc;
  logic [DUR_W-1:0]  r_ms, w_ms;

  logic [HP_W+DUR_W-1:0] w_entry;
  logic [HP_W-1:0]       w_ent_hp;
  logic [DUR_W-1:0]      w_ent_dur;
  logic                  w_start_ok;
  logic                  w_last;
  logic                  w_wrap;
  logic                  w_adv;
  state_t                w_adv_state;
  logic [AW-1:0]         w_adv_idx;

  // Table has no reset; an entry is sampled only when its LOAD reads it.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign w_entry    = r_mem[r_idx];
  assign w_ent_hp   = w_entry[HP_W+DUR_W-1:DUR_W];
  assign w_ent_dur  = w_entry[DUR_W-1:0];
  assign w_start_ok = bus.start && !bus.stop && (bus.num_notes != '0) &&
                      (bus.num_notes <= (AW+1)'(DEPTH));
  assign w_last     = ({1'b0, r_idx} == (r_num - (AW+1)'(1)));
  assign w_wrap     = (r_presc == PW'(MS_COUNT - 1));

  // Advance target shared by LOAD (dur=0), PLAY (no gap) and GAP exits.
  always_comb begin
    w_adv_state = S_LOAD;
    w_adv_idx   = r_idx + 1'b1;
    if (w_last) begin
      if (r_loop) begin
        w_adv_idx = '0;
      end else begin
        w_adv_state = S_DONE;
        w_adv_idx   = r_idx;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_num   = r_num;
    w_loop  = r_loop;
    w_busy  = r_busy;
    w_tone  = r_tone;
    w_hp    = r_hp;
    w_presc = r_presc;
    w_ms    = r_ms;
    w_adv   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state = S_LOAD;
          w_num   = bus.num_notes;
          w_loop  = bus.loop;
          w_idx   = '0;
          w_busy  = 1'b1;
        end
      end

      S_LOAD: begin
        if (bus.stop) begin
          w_state = S_IDLE;
          w_tone  = 1'b0;
          w_busy  = 1'b0;
        end else if (w_ent_dur == '0) begin
          w_adv = 1'b1;
        end else begin
          w_state = S_PLAY;
          w_hp    = w_ent_hp;
          w_tone  = (w_ent_hp != '0);
          w_presc = '0;
          w_ms    = w_ent_dur;
        end
      end

      S_PLAY: begin
        if (bus.stop) begin
          w_state = S_IDLE;
          w_tone  = 1'b0;
          w_busy  = 1'b0;
        end else if (w_wrap) begin
          w_presc = '0;
          if (r_ms == DUR_W'(1)) begin
            w_tone = 1'b0;
            if (GAP_MS == 0) begin
              w_adv = 1'b1;
            end else begin
              w_state = S_GAP;
              w_ms    = DUR_W'(GAP_MS);
            end
          end else begin
            w_ms = r_ms - 1'b1;
          end
        end else begin
          w_presc = r_presc + 1'b1;
        end
      end

      S_GAP: begin
        if (bus.stop) begin
          w_state = S_IDLE;
          w_tone  = 1'b0;
          w_busy  = 1'b0;
        end else if (w_wrap) begin
          w_presc = '0;
          if (r_ms == DUR_W'(1)) begin
            w_adv = 1'b1;
          end else begin
            w_ms = r_ms - 1'b1;
          end
        end else begin
          w_presc = r_presc + 1'b1;
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end

      default: begin
        w_state = S_IDLE;
        w_tone  = 1'b0;
        w_busy  = 1'b0;
      end
    endcase

    if (w_adv) begin
      w_state = w_adv_state;
      w_idx   = w_adv_idx;
    end

    w_done = (w_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_num   <= '0;
      r_loop  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tone  <= 1'b0;
      r_hp    <= '0;
      r_presc <= '0;
      r_ms    <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_num   <= w_num;
      r_loop  <= w_loop;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_tone  <= w_tone;
      r_hp    <= w_hp;
      r_presc <= w_presc;
      r_ms    <= w_ms;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.note_idx    = r_idx;
  assign bus.tone_en     = r_tone;
  assign bus.half_period = r_hp;

endmodule
